// File: rtl/mipsmc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU control codes and the internal ALU-operation selector.
package mipsmc_pkg;

    typedef enum logic [4:0] {
        StFetch   = 5'd0,
        StDecode  = 5'd1,
        StMemAdr  = 5'd2,
        StMemRd   = 5'd3,
        StMemWb   = 5'd4,
        StMemWr   = 5'd5,
        StRtypeEx = 5'd6,
        StRtypeWb = 5'd7,
        StBeqEx   = 5'd8,
        StBneEx   = 5'd9,
        StImmEx   = 5'd10,
        StIwb     = 5'd11,
        StJEx     = 5'd12,
        StJalEx   = 5'd13,
        StTrap    = 5'd14
    } state_e;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    // R-type funct codes
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    // ALU control codes
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    // Operation requested by the FSM; AluOpFunct defers to the R-type funct field
    typedef enum logic [2:0] {
        AluOpNone,
        AluOpAdd,
        AluOpSub,
        AluOpAnd,
        AluOpOr,
        AluOpFunct
    } aluop_e;

    function automatic logic funct_ok(input logic [5:0] fn);
        return (fn == FnAdd) || (fn == FnSub) || (fn == FnAnd) || (fn == FnOr) || (fn == FnSlt);
    endfunction

endpackage

// File: rtl/mipsmc_aludec.sv
// Combinational ALU decoder: maps the FSM's requested operation (and the
// R-type funct field) to the 3-bit ALU control code.
module mipsmc_aludec
    import mipsmc_pkg::*;
(
    input  aluop_e     i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    // Operation decode; idle states drive an all-zero code
    always_comb begin
        o_alucontrol = 3'b000;
        case (i_aluop)
            AluOpAdd: o_alucontrol = AluAdd;
            AluOpSub: o_alucontrol = AluSub;
            AluOpAnd: o_alucontrol = AluAnd;
            AluOpOr:  o_alucontrol = AluOr;
            AluOpFunct: begin
                case (i_funct)
                    FnSub:   o_alucontrol = AluSub;
                    FnAnd:   o_alucontrol = AluAnd;
                    FnOr:    o_alucontrol = AluOr;
                    FnSlt:   o_alucontrol = AluSlt;
                    default: o_alucontrol = AluAdd;
                endcase
            end
            default: o_alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/mipsmc_ctrl.sv
// Multicycle MIPS control FSM with bounded memory waits and a sticky trap state.
module mipsmc_ctrl
    import mipsmc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter bit          EXT_EN   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_memready,
    output logic       o_memreq,
    output logic       o_pcen,
    output logic       o_irwrite,
    output logic       o_regwrite,
    output logic       o_memwrite,
    output logic       o_alusrca,
    output logic       o_iord,
    output logic       o_immzext,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic [1:0] o_regdst,
    output logic [1:0] o_memtoreg,
    output logic [2:0] o_alucontrol,
    output logic       o_fault,
    output logic [4:0] o_state
);

    localparam int unsigned    WaitW    = $clog2(WAIT_MAX + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

    state_e           r_state;
    logic [WaitW-1:0] r_wait;
    state_e           w_decode_next;
    aluop_e           w_aluop;
    logic             w_mem_state;
    logic             w_timeout;

    assign w_mem_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
    // Success on the last allowed cycle wins, so timeout only fires with memready low
    assign w_timeout   = w_mem_state && !i_memready && (r_wait == WaitLast);

    // Opcode dispatch out of DECODE; extension opcodes trap when disabled
    always_comb begin
        w_decode_next = StTrap;
        case (i_op)
            OpLw, OpSw:    w_decode_next = StMemAdr;
            OpRtype:       w_decode_next = funct_ok(i_funct) ? StRtypeEx : StTrap;
            OpBeq:         w_decode_next = StBeqEx;
            OpBne:         w_decode_next = EXT_EN ? StBneEx : StTrap;
            OpAddi:        w_decode_next = StImmEx;
            OpAndi, OpOri: w_decode_next = EXT_EN ? StImmEx : StTrap;
            OpJ:           w_decode_next = StJEx;
            OpJal:         w_decode_next = EXT_EN ? StJalEx : StTrap;
            default:       w_decode_next = StTrap;
        endcase
    end

    // State register and memory-wait counter (counter is zero whenever a memory state is entered)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StFetch;
            r_wait  <= '0;
        end else begin
            if (w_mem_state && !i_memready) r_wait <= r_wait + WaitW'(1);
            else                            r_wait <= '0;
            case (r_state)
                StFetch:   r_state <= i_memready ? StDecode : (w_timeout ? StTrap : StFetch);
                StDecode:  r_state <= w_decode_next;
                StMemAdr:  r_state <= (i_op == OpLw) ? StMemRd : StMemWr;
                StMemRd:   r_state <= i_memready ? StMemWb : (w_timeout ? StTrap : StMemRd);
                StMemWr:   r_state <= i_memready ? StFetch : (w_timeout ? StTrap : StMemWr);
                StRtypeEx: r_state <= StRtypeWb;
                StImmEx:   r_state <= StIwb;
                StMemWb, StRtypeWb, StBeqEx, StBneEx, StIwb, StJEx, StJalEx: r_state <= StFetch;
                StTrap:    r_state <= StTrap;
                default:   r_state <= StTrap;
            endcase
        end
    end

    // Moore outputs per state; FETCH and branch strobes follow memready/zero directly
    always_comb begin
        o_memreq   = 1'b0;
        o_pcen     = 1'b0;
        o_irwrite  = 1'b0;
        o_regwrite = 1'b0;
        o_memwrite = 1'b0;
        o_alusrca  = 1'b0;
        o_iord     = 1'b0;
        o_immzext  = 1'b0;
        o_alusrcb  = 2'b00;
        o_pcsrc    = 2'b00;
        o_regdst   = 2'b00;
        o_memtoreg = 2'b00;
        w_aluop    = AluOpNone;
        case (r_state)
            StFetch: begin
                o_memreq  = 1'b1;
                o_alusrcb = 2'b01;
                w_aluop   = AluOpAdd;
                o_irwrite = i_memready;
                o_pcen    = i_memready;
            end
            StDecode: begin
                o_alusrcb = 2'b11;
                w_aluop   = AluOpAdd;
            end
            StMemAdr: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                w_aluop   = AluOpAdd;
            end
            StMemRd: begin
                o_memreq = 1'b1;
                o_iord   = 1'b1;
            end
            StMemWb: begin
                o_regwrite = 1'b1;
                o_memtoreg = 2'b01;
            end
            StMemWr: begin
                o_memreq   = 1'b1;
                o_memwrite = 1'b1;
                o_iord     = 1'b1;
            end
            StRtypeEx: begin
                o_alusrca = 1'b1;
                w_aluop   = AluOpFunct;
            end
            StRtypeWb: begin
                o_regwrite = 1'b1;
                o_regdst   = 2'b01;
            end
            StBeqEx, StBneEx: begin
                o_alusrca = 1'b1;
                w_aluop   = AluOpSub;
                o_pcsrc   = 2'b01;
                o_pcen    = (r_state == StBeqEx) ? i_zero : !i_zero;
            end
            StImmEx: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                o_immzext = (i_op == OpAndi) || (i_op == OpOri);
                w_aluop   = (i_op == OpAndi) ? AluOpAnd : ((i_op == OpOri) ? AluOpOr : AluOpAdd);
            end
            StIwb: o_regwrite = 1'b1;
            StJEx, StJalEx: begin
                o_pcsrc = 2'b10;
                o_pcen  = 1'b1;
                if (r_state == StJalEx) begin
                    o_regwrite = 1'b1;
                    o_regdst   = 2'b10;
                    o_memtoreg = 2'b10;
                end
            end
            default: ;
        endcase
        // No strobe may escape while reset is held, even from a mid-access state
        if (i_reset) begin
            o_memreq   = 1'b0;
            o_pcen     = 1'b0;
            o_irwrite  = 1'b0;
            o_regwrite = 1'b0;
            o_memwrite = 1'b0;
        end
    end

    mipsmc_aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (i_funct),
        .o_alucontrol (o_alucontrol)
    );

    assign o_fault = (r_state == StTrap);
    assign o_state = r_state;

endmodule

// File: tb/tb_mipsmc_ctrl.sv
// Randomized instruction-level bench for mipsmc_ctrl with a phase-list reference model.
module tb_mipsmc_ctrl;
    import mipsmc_pkg::*;

    localparam int WaitMax = 16;

    logic       clk, reset, zero, memready;
    logic [5:0] op, funct;
    logic       memreq, pcen, irwrite, regwrite, memwrite, alusrca, iord, immzext, fault;
    logic [1:0] alusrcb, pcsrc, regdst, memtoreg;
    logic [2:0] alucontrol;
    logic [4:0] dut_state;
    // Second instance with extensions disabled
    logic       n_memreq, n_pcen, n_irwrite, n_regwrite, n_memwrite, n_alusrca, n_iord;
    logic       n_immzext, n_fault;
    logic [1:0] n_alusrcb, n_pcsrc, n_regdst, n_memtoreg;
    logic [2:0] n_alucontrol;
    logic [4:0] n_state;

    int     n_checks = 0;
    int     n_errors = 0;
    bit     timed_out;
    bit     chk_noext = 1'b0;
    state_e noext_exp;
    state_e path[$];

    mipsmc_ctrl #(.WAIT_MAX(WaitMax), .EXT_EN(1'b1)) dut (
        .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
        .i_memready(memready), .o_memreq(memreq), .o_pcen(pcen), .o_irwrite(irwrite),
        .o_regwrite(regwrite), .o_memwrite(memwrite), .o_alusrca(alusrca), .o_iord(iord),
        .o_immzext(immzext), .o_alusrcb(alusrcb), .o_pcsrc(pcsrc), .o_regdst(regdst),
        .o_memtoreg(memtoreg), .o_alucontrol(alucontrol), .o_fault(fault), .o_state(dut_state)
    );

    mipsmc_ctrl #(.WAIT_MAX(WaitMax), .EXT_EN(1'b0)) dut_noext (
        .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
        .i_memready(memready), .o_memreq(n_memreq), .o_pcen(n_pcen), .o_irwrite(n_irwrite),
        .o_regwrite(n_regwrite), .o_memwrite(n_memwrite), .o_alusrca(n_alusrca),
        .o_iord(n_iord), .o_immzext(n_immzext), .o_alusrcb(n_alusrcb), .o_pcsrc(n_pcsrc),
        .o_regdst(n_regdst), .o_memtoreg(n_memtoreg), .o_alucontrol(n_alucontrol),
        .o_fault(n_fault), .o_state(n_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
        case (fn)
            FnSub:   return AluSub;
            FnAnd:   return AluAnd;
            FnOr:    return AluOr;
            FnSlt:   return AluSlt;
            default: return AluAdd;
        endcase
    endfunction

    function automatic logic [19:0] act_ctrl();
        return {memreq, pcen, irwrite, regwrite, memwrite, alusrca, iord, immzext,
                alusrcb, pcsrc, regdst, memtoreg, alucontrol, fault};
    endfunction

    // Expected control word for a phase given the current inputs
    function automatic logic [19:0] exp_ctrl(input state_e st);
        logic mq = 0, pe = 0, iw = 0, rw = 0, mw = 0, sa = 0, io = 0, zx = 0, ft = 0;
        logic [1:0] sb = 0, ps = 0, rd = 0, mr = 0;
        logic [2:0] al = 0;
        case (st)
            StFetch:   begin mq = 1; sb = 2'b01; al = AluAdd; iw = memready; pe = memready; end
            StDecode:  begin sb = 2'b11; al = AluAdd; end
            StMemAdr:  begin sa = 1; sb = 2'b10; al = AluAdd; end
            StMemRd:   begin mq = 1; io = 1; end
            StMemWb:   begin rw = 1; mr = 2'b01; end
            StMemWr:   begin mq = 1; mw = 1; io = 1; end
            StRtypeEx: begin sa = 1; al = alu_of_funct(funct); end
            StRtypeWb: begin rw = 1; rd = 2'b01; end
            StBeqEx:   begin sa = 1; al = AluSub; ps = 2'b01; pe = zero; end
            StBneEx:   begin sa = 1; al = AluSub; ps = 2'b01; pe = !zero; end
            StImmEx: begin
                sa = 1; sb = 2'b10; zx = (op != OpAddi);
                al = (op == OpAddi) ? AluAdd : ((op == OpAndi) ? AluAnd : AluOr);
            end
            StIwb:     rw = 1;
            StJEx:     begin ps = 2'b10; pe = 1; end
            StJalEx:   begin ps = 2'b10; pe = 1; rw = 1; rd = 2'b10; mr = 2'b10; end
            default:   ft = 1;
        endcase
        return {mq, pe, iw, rw, mw, sa, io, zx, sb, ps, rd, mr, al, ft};
    endfunction

    // Phases an instruction visits after DECODE
    task automatic plan(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OpLw:    path = '{StMemAdr, StMemRd, StMemWb};
            OpSw:    path = '{StMemAdr, StMemWr};
            OpRtype: begin
                if (f inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt}) path = '{StRtypeEx, StRtypeWb};
                else path = '{StTrap};
            end
            OpBeq:   path = '{StBeqEx};
            OpBne:   path = '{StBneEx};
            OpAddi, OpAndi, OpOri: path = '{StImmEx, StIwb};
            OpJ:     path = '{StJEx};
            OpJal:   path = '{StJalEx};
            default: path = '{StTrap};
        endcase
    endtask

    task automatic rnd_inputs();
        memready = 1'($urandom);
        zero     = 1'($urandom);
    endtask

    task automatic cyc(input state_e st);
        @(negedge clk);
        check("state", 32'(dut_state), 32'(st));
        check($sformatf("ctrl@%0d", st), 32'(act_ctrl()), 32'(exp_ctrl(st)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            rnd_inputs();
            @(negedge clk);
            check("rst_strobes", 32'({memreq, pcen, irwrite, regwrite, memwrite}), 32'(0));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // waits == WaitMax means memready never arrives
    task automatic mem_phase(input state_e st, input int waits);
        timed_out = 1'b0;
        for (int k = 0; k < WaitMax; k++) begin
            memready = (k == waits);
            zero     = 1'($urandom);
            cyc(st);
            if (k == waits) return;
        end
        timed_out = 1'b1;
    endtask

    task automatic expect_trap();
        for (int i = 0; i < 3; i++) begin
            rnd_inputs();
            cyc(StTrap);
        end
        do_reset(1 + $urandom_range(0, 1));
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
        plan(o, f);
        op    = o;
        funct = f;
        mem_phase(StFetch, wf);
        if (timed_out) begin expect_trap(); return; end
        rnd_inputs();
        cyc(StDecode);
        if (chk_noext) begin
            check("noext_state", 32'(n_state), 32'(noext_exp));
            check("noext_fault", 32'(n_fault), 32'(noext_exp == StTrap));
        end
        foreach (path[i]) begin
            if (path[i] == StMemRd || path[i] == StMemWr) begin
                mem_phase(path[i], wm);
                if (timed_out) begin expect_trap(); return; end
            end else if (path[i] == StTrap) begin
                expect_trap();
                return;
            end else begin
                rnd_inputs();
                cyc(path[i]);
            end
        end
    endtask

    function automatic int pick_wait();
        int r = $urandom_range(0, 39);
        if (r < 34) return $urandom_range(0, 3);
        if (r < 37) return WaitMax - 1;
        return WaitMax;
    endfunction

    initial begin
        logic [5:0] ops [10] = '{OpRtype, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpAndi, OpOri,
                                 OpJ, OpJal};
        logic [5:0] fns [5]  = '{FnAdd, FnSub, FnAnd, FnOr, FnSlt};
        logic [5:0] o, f;
        op = '0; funct = '0; zero = 1'b0; memready = 1'b0;
        do_reset(2);

        run_instr(OpLw, 6'd0, 2, 0);            // fetch waits two cycles
        run_instr(OpLw, 6'd0, 0, 0);            // lw with memready always high
        for (int z = 0; z < 2; z++) begin       // bne with zero forced both ways
            op = OpBne; memready = 1'b1; cyc(StFetch);
            cyc(StDecode);
            zero = 1'(z); cyc(StBneEx);
        end
        run_instr(OpJal, 6'd0, 0, 0);
        run_instr(OpSw, 6'd0, 0, WaitMax);      // write times out
        run_instr(OpSw, 6'd0, 1, WaitMax - 1);  // completes on the last allowed cycle
        run_instr(OpLw, 6'd0, WaitMax - 1, WaitMax);
        run_instr(OpRtype, 6'b111111, 0, 0);    // bad funct
        run_instr(6'b111111, 6'd0, 0, 0);       // unknown opcode

        chk_noext = 1'b1;
        noext_exp = StTrap;   run_instr(OpAndi, 6'd0, 1, 0);
        do_reset(1);
        noext_exp = StImmEx;  run_instr(OpAddi, 6'd0, 0, 0);
        noext_exp = StTrap;   run_instr(OpJal, 6'd0, 0, 0);
        chk_noext = 1'b0;
        do_reset(1);

        // Reset asserted while a load is waiting in MEMRD
        op = OpLw; funct = '0; memready = 1'b1; cyc(StFetch);
        rnd_inputs(); cyc(StDecode);
        cyc(StMemAdr);
        memready = 1'b0; cyc(StMemRd);
        do_reset(1);
        run_instr(OpOri, 6'd0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(0, 19);
            o = (r == 19) ? 6'($urandom) : ops[r % 10];
            f = ($urandom_range(0, 7) < 7) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(o, f, pick_wait(), pick_wait());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
